// File: rtl/sum_window_accumulator_if.sv
// Handshake bundle for sum_window_accumulator.
//   Input side : in_data / in_valid / in_ready, plus flush to close a
//                partial window early.
//   Output side: out_byte / out_valid / out_ready, plus out_last (high
//                byte marker) and win_count (samples in the emitted result).
// The slave modport is the accumulator itself; the master modport is the
// surrounding logic that feeds sums in and drains result bytes.
interface sum_window_accumulator_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic [7:0]        out_byte;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [4:0]        win_count;

    modport slave (
        input  in_data, in_valid, flush, out_ready,
        output in_ready, out_byte, out_valid, out_last, win_count
    );

    modport master (
        output in_data, in_valid, flush, out_ready,
        input  in_ready, out_byte, out_valid, out_last, win_count
    );
endinterface

// File: rtl/sum_window_accumulator.sv
// Window accumulator sitting after the 8-bit adder stage.
// Accepts sums over a valid/ready handshake, adds WINDOW of them (or fewer
// when flush closes the window early) into a DATA_W+4 bit total, then emits
// the total as two bytes, low byte first, on a byte-wide valid/ready output.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - sum_window_accumulator_if.slave (input sums, flush, result bytes,
//          out_last marker, win_count of the emitted result)
module sum_window_accumulator #(
    parameter int DATA_W = 8,
    parameter int WINDOW = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    sum_window_accumulator_if.slave       bus
);
    localparam int ACC_W = DATA_W + 4;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        EMIT_LO = 2'd1,
        EMIT_HI = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [ACC_W-1:0] result_q, result_d;
    logic [4:0]       res_cnt_q, res_cnt_d;
    logic [7:0]       out_byte_q, out_byte_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;

    logic             in_ready;
    logic             xfer;
    logic [ACC_W-1:0] sum;
    logic [15:0]      result_ext;

    // Ready is gated by rst so nothing is accepted during the reset cycle.
    assign in_ready   = (state_q == ACCUM) && !rst;
    assign xfer       = bus.in_valid && in_ready;
    assign sum        = acc_q + ACC_W'(bus.in_data);
    assign result_ext = 16'(result_q);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        res_cnt_d   = res_cnt_q;
        out_byte_d  = out_byte_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        case (state_q)
            ACCUM: begin
                // A closing transfer wins over a simultaneous flush, which
                // yields the same result with res_cnt = WINDOW.
                if (xfer && (cnt_q == 5'(WINDOW - 1))) begin
                    result_d    = sum;
                    res_cnt_d   = 5'(WINDOW);
                    acc_d       = '0;
                    cnt_d       = '0;
                    state_d     = EMIT_LO;
                    out_valid_d = 1'b1;
                    out_byte_d  = sum[7:0];
                    out_last_d  = 1'b0;
                end else if (bus.flush && ((cnt_q != 5'd0) || xfer)) begin
                    result_d    = xfer ? sum : acc_q;
                    res_cnt_d   = cnt_q + 5'(xfer);
                    acc_d       = '0;
                    cnt_d       = '0;
                    state_d     = EMIT_LO;
                    out_valid_d = 1'b1;
                    out_byte_d  = xfer ? sum[7:0] : acc_q[7:0];
                    out_last_d  = 1'b0;
                end else if (xfer) begin
                    acc_d = sum;
                    cnt_d = cnt_q + 5'd1;
                end
            end
            EMIT_LO: begin
                if (bus.out_ready) begin
                    state_d    = EMIT_HI;
                    out_byte_d = result_ext[15:8];
                    out_last_d = 1'b1;
                end
            end
            EMIT_HI: begin
                if (bus.out_ready) begin
                    state_d     = ACCUM;
                    out_valid_d = 1'b0;
                    out_byte_d  = 8'd0;
                    out_last_d  = 1'b0;
                end
            end
            default: begin
                state_d     = ACCUM;
                out_valid_d = 1'b0;
                out_byte_d  = 8'd0;
                out_last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            res_cnt_q   <= '0;
            out_byte_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            res_cnt_q   <= res_cnt_d;
            out_byte_q  <= out_byte_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_byte  = out_byte_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.win_count = res_cnt_q;
endmodule

// File: tb/tb_sum_window_accumulator.sv
module tb_sum_window_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sum_window_accumulator_if #(.DATA_W(8)) b4 ();
    sum_window_accumulator_if #(.DATA_W(8)) b16 ();

    sum_window_accumulator #(.DATA_W(8), .WINDOW(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (b4)
    );

    sum_window_accumulator #(.DATA_W(8), .WINDOW(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (b16)
    );

    typedef struct packed {
        logic [7:0] b;
        logic       last;
        logic [4:0] wc;
    } exp_t;

    exp_t q4[$];
    exp_t q16[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic push4(input logic [7:0] lo, input logic [7:0] hi, input logic [4:0] wc);
        q4.push_back('{b: lo, last: 1'b0, wc: wc});
        q4.push_back('{b: hi, last: 1'b1, wc: wc});
    endtask

    // Scoreboard monitors: a handshake is seen at the negedge before the edge
    // that completes it.
    always @(negedge clk) begin
        if (b4.out_valid && b4.out_ready) begin
            if (q4.size() == 0) begin
                chk("w4_unexpected_byte", 1, 0);
            end else begin
                exp_t e;
                e = q4.pop_front();
                chk("w4_out_byte", int'(b4.out_byte), int'(e.b));
                chk("w4_out_last", int'(b4.out_last), int'(e.last));
                chk("w4_win_count", int'(b4.win_count), int'(e.wc));
            end
        end
    end

    always @(negedge clk) begin
        if (b16.out_valid && b16.out_ready) begin
            if (q16.size() == 0) begin
                chk("w16_unexpected_byte", 1, 0);
            end else begin
                exp_t e;
                e = q16.pop_front();
                chk("w16_out_byte", int'(b16.out_byte), int'(e.b));
                chk("w16_out_last", int'(b16.out_last), int'(e.last));
                chk("w16_win_count", int'(b16.win_count), int'(e.wc));
            end
        end
    end

    // All stimulus tasks start and end at posedge+1.
    task automatic send4(input logic [7:0] v, input logic fl);
        logic rdy;
        int   n;
        b4.in_data  = v;
        b4.in_valid = 1'b1;
        b4.flush    = fl;
        rdy = 1'b0;
        for (n = 0; n < 50 && !rdy; n++) begin
            @(negedge clk);
            rdy = b4.in_ready;
            @(posedge clk);
            #1;
        end
        if (!rdy) chk("w4_send_timeout", 0, 1);
        b4.in_valid = 1'b0;
        b4.flush    = 1'b0;
    endtask

    task automatic send16(input logic [7:0] v);
        logic rdy;
        int   n;
        b16.in_data  = v;
        b16.in_valid = 1'b1;
        rdy = 1'b0;
        for (n = 0; n < 50 && !rdy; n++) begin
            @(negedge clk);
            rdy = b16.in_ready;
            @(posedge clk);
            #1;
        end
        if (!rdy) chk("w16_send_timeout", 0, 1);
        b16.in_valid = 1'b0;
    endtask

    task automatic wait_idle4();
        logic idle;
        idle = 1'b0;
        for (int n = 0; n < 50 && !idle; n++) begin
            @(negedge clk);
            idle = b4.in_ready && !b4.out_valid;
            @(posedge clk);
            #1;
        end
        if (!idle) chk("w4_idle_timeout", 0, 1);
    endtask

    task automatic wait_idle16();
        logic idle;
        idle = 1'b0;
        for (int n = 0; n < 80 && !idle; n++) begin
            @(negedge clk);
            idle = b16.in_ready && !b16.out_valid;
            @(posedge clk);
            #1;
        end
        if (!idle) chk("w16_idle_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int zero_rdy;
        b4.in_data = '0;  b4.in_valid = 1'b0;  b4.flush = 1'b0;  b4.out_ready = 1'b1;
        b16.in_data = '0; b16.in_valid = 1'b0; b16.flush = 1'b0; b16.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready_forced_low", int'(b4.in_ready), 0);
        chk("rst_out_valid", int'(b4.out_valid), 0);
        chk("rst_out_byte", int'(b4.out_byte), 0);
        chk("rst_out_last", int'(b4.out_last), 0);
        chk("rst_win_count", int'(b4.win_count), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", int'(b4.in_ready), 1);
        @(posedge clk);
        #1;

        // Full window 10+20+30+40 = 100 = 0x064
        push4(8'h64, 8'h00, 5'd4);
        send4(8'd10, 1'b0);
        send4(8'd20, 1'b0);
        send4(8'd30, 1'b0);
        send4(8'd40, 1'b0);
        zero_rdy = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (b4.in_ready) break;
            zero_rdy++;
        end
        @(posedge clk);
        #1;
        chk("full_in_ready_low_cycles", zero_rdy, 2);
        wait_idle4();

        // Flush after 1,2,3 -> 6, win_count 3
        push4(8'h06, 8'h00, 5'd3);
        send4(8'd1, 1'b0);
        send4(8'd2, 1'b0);
        send4(8'd3, 1'b0);
        b4.flush = 1'b1;
        @(posedge clk);
        #1;
        b4.flush = 1'b0;
        wait_idle4();
        chk("flush_win_count_held", int'(b4.win_count), 3);

        // Flush on an empty window emits nothing
        b4.flush = 1'b1;
        @(posedge clk);
        #1;
        b4.flush = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("empty_flush_no_output", int'(b4.out_valid), 0);
            @(posedge clk);
            #1;
        end

        // Backpressure during the low byte
        b4.out_ready = 1'b0;
        push4(8'h64, 8'h00, 5'd4);
        send4(8'd10, 1'b0);
        send4(8'd20, 1'b0);
        send4(8'd30, 1'b0);
        send4(8'd40, 1'b0);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("bp_out_valid", int'(b4.out_valid), 1);
            chk("bp_out_byte", int'(b4.out_byte), 8'h64);
            chk("bp_in_ready", int'(b4.in_ready), 0);
            @(posedge clk);
            #1;
        end
        b4.out_ready = 1'b1;
        wait_idle4();

        // Reset while the high byte is pending: low byte goes out, high does not
        q4.push_back('{b: 8'h64, last: 1'b0, wc: 5'd4});
        send4(8'd10, 1'b0);
        send4(8'd20, 1'b0);
        send4(8'd30, 1'b0);
        send4(8'd40, 1'b0);
        @(posedge clk);
        #1;
        b4.out_ready = 1'b0;
        @(negedge clk);
        chk("rst_mid_in_emit_hi", int'(b4.out_last), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        b4.out_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_out_valid", int'(b4.out_valid), 0);
        chk("rst_mid_win_count", int'(b4.win_count), 0);
        @(posedge clk);
        #1;
        push4(8'h14, 8'h00, 5'd4);
        for (int i = 0; i < 4; i++) send4(8'd5, 1'b0);
        wait_idle4();

        // Flush coinciding with the closing transfer -> one full window of 10
        push4(8'h0A, 8'h00, 5'd4);
        send4(8'd1, 1'b0);
        send4(8'd2, 1'b0);
        send4(8'd3, 1'b0);
        send4(8'd4, 1'b1);
        wait_idle4();
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("simul_no_extra_output", int'(b4.out_valid), 0);
            @(posedge clk);
            #1;
        end

        // Maximum sum with WINDOW=16: 16*255 = 4080 = 0xFF0
        q16.push_back('{b: 8'hF0, last: 1'b0, wc: 5'd16});
        q16.push_back('{b: 8'h0F, last: 1'b1, wc: 5'd16});
        for (int i = 0; i < 16; i++) send16(8'hFF);
        wait_idle16();

        chk("w4_queue_drained", q4.size(), 0);
        chk("w16_queue_drained", q16.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
